// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared CPU constants: bus widths, opcode values and the
//                encodings of the IR byte-assembly state.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int OPC_W   = 3;
    localparam int INSTR_W = OPC_W + ADDR_W;

    typedef enum logic [OPC_W-1:0] {
        HLT  = 3'b000,
        SKZ  = 3'b001,
        ADD  = 3'b010,
        ANDD = 3'b011,
        XORR = 3'b100,
        LDA  = 3'b101,
        STO  = 3'b110,
        JMP  = 3'b111
    } opcode_t;

    // Which IR byte the next load_ir writes; the value is exported as byte_sel.
    typedef enum logic [0:0] {
        BYTE_HI = 1'b0,
        BYTE_LO = 1'b1
    } byte_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Control strobes, memory data and fetch-unit outputs bundled
//                between the control FSM (master) and the fetch unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              fetch;
    logic              load_ir;
    logic              inc_pc;
    logic              load_pc;
    logic              halt;
    logic [DATA_W-1:0] data;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] addr;
    logic              ir_valid;
    logic              byte_sel;
    logic              halted;

    modport master (
        output fetch, load_ir, inc_pc, load_pc, halt, data,
        input  opcode, ir_addr, pc_addr, addr, ir_valid, byte_sel, halted
    );

    modport slave (
        input  fetch, load_ir, inc_pc, load_pc, halt, data,
        output opcode, ir_addr, pc_addr, addr, ir_valid, byte_sel, halted
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pc_counter
//  Description : Program counter with load-over-increment priority and
//                natural wrap at 2^ADDR_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_counter
    import fetch_unit_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en_i,
    input  wire logic              load_i,
    input  wire logic              inc_i,
    input  wire logic [ADDR_W-1:0] load_val_i,
    output logic      [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;

    // PC register: load wins over increment; en_i low freezes the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else if (en_i) begin
            if (load_i) begin
                pc_q <= load_val_i;
            end else if (inc_i) begin
                pc_q <= pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch datapath: PC, two-byte IR assembly,
//                sticky halt flag and the memory address mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    fetch_unit_if.slave bus
);

    byte_state_t        state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic               halted_q, halted_d;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_ir_addr;

    assign w_ir_addr = ir_q[ADDR_W-1:0];

    // The PC loads from the IR as it stood before this edge, so a byte being
    // captured in the same cycle can never leak into the jump target.
    pc_counter u_pc_counter (
        .clk        (clk),
        .rst        (rst),
        .en_i       (!halted_q),
        .load_i     (bus.load_pc),
        .inc_i      (bus.inc_pc),
        .load_val_i (w_ir_addr),
        .pc_o       (w_pc)
    );

    // State register for byte assembly, IR, valid flag and halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BYTE_HI;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state: capture bytes high then low; a halt seen this cycle still
    // lets this cycle's capture complete, and freezes everything afterwards.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q | bus.halt;
        if (!halted_q && bus.load_ir) begin
            case (state_q)
                BYTE_HI: begin
                    ir_d[INSTR_W-1 -: DATA_W] = bus.data;
                    ir_valid_d                = 1'b0;
                    state_d                   = BYTE_LO;
                end
                BYTE_LO: begin
                    ir_d[DATA_W-1:0] = bus.data;
                    ir_valid_d       = 1'b1;
                    state_d          = BYTE_HI;
                end
                default: begin
                    state_d = BYTE_HI;
                end
            endcase
        end
    end

    assign bus.opcode   = ir_q[INSTR_W-1 -: OPC_W];
    assign bus.ir_addr  = w_ir_addr;
    assign bus.pc_addr  = w_pc;
    assign bus.addr     = bus.fetch ? w_pc : w_ir_addr;
    assign bus.ir_valid = ir_valid_q;
    assign bus.byte_sel = state_q;
    assign bus.halted   = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with an
//                expected-value scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int S_OPC = 0, S_IRA = 1, S_PC = 2, S_ADDR = 3,
                   S_VAL = 4, S_BSEL = 5, S_HALT = 6;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    fetch_unit_if ifc ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            S_OPC:   return {13'd0, ifc.opcode};
            S_IRA:   return {3'd0, ifc.ir_addr};
            S_PC:    return {3'd0, ifc.pc_addr};
            S_ADDR:  return {3'd0, ifc.addr};
            S_VAL:   return {15'd0, ifc.ir_valid};
            S_BSEL:  return {15'd0, ifc.byte_sel};
            default: return {15'd0, ifc.halted};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t        e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            vectors++;
            assert (o === e.val)
            else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic drive(input logic r, input logic lir, input logic inc,
                         input logic lpc, input logic h, input logic [7:0] d);
        rst         = r;
        ifc.load_ir = lir;
        ifc.inc_pc  = inc;
        ifc.load_pc = lpc;
        ifc.halt    = h;
        ifc.data    = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic load_word(input logic [7:0] hi, input logic [7:0] lo);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, hi);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lo);
        tick();
    endtask

    task automatic expect_reset_state(input string tag);
        expect_out({tag, "_pc"},     S_PC,   16'h0000);
        expect_out({tag, "_opcode"}, S_OPC,  16'h0000);
        expect_out({tag, "_iraddr"}, S_IRA,  16'h0000);
        expect_out({tag, "_bsel"},   S_BSEL, 16'h0000);
        expect_out({tag, "_valid"},  S_VAL,  16'h0000);
        expect_out({tag, "_halted"}, S_HALT, 16'h0000);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ifc.fetch   = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_reset_state("reset");
        expect_out("reset_addr", S_ADDR, 16'h0000);
        tick();
        compare_all();

        // IR assembly: LDA 0x0012
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA0);
        expect_out("asm_hi_bsel",  S_BSEL, 16'h0001);
        expect_out("asm_hi_valid", S_VAL,  16'h0000);
        tick();
        compare_all();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12);
        expect_out("asm_lo_opcode", S_OPC,  16'h0005);
        expect_out("asm_lo_iraddr", S_IRA,  16'h0012);
        expect_out("asm_lo_valid",  S_VAL,  16'h0001);
        expect_out("asm_lo_bsel",   S_BSEL, 16'h0000);
        tick();
        compare_all();

        // load_pc with load_ir: PC takes the old ir_addr, not the new byte
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h77);
        expect_out("lpc_lir_pc",    S_PC,   16'h0012);
        expect_out("lpc_lir_bsel",  S_BSEL, 16'h0001);
        expect_out("lpc_lir_valid", S_VAL,  16'h0000);
        tick();
        compare_all();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("lir_inc_pc",  S_PC,  16'h0013);
        expect_out("lir_inc_ir",  S_OPC, 16'h0003);
        tick();
        compare_all();

        // PC wrap from 0x1FFE
        load_word(8'h1F, 8'hFE);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        expect_out("wrap_preset", S_PC, 16'h1FFE);
        tick();
        compare_all();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_inc1", S_PC, 16'h1FFF);
        tick();
        compare_all();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_inc2", S_PC, 16'h0000);
        tick();
        compare_all();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("wrap_inc3", S_PC, 16'h0001);
        tick();
        compare_all();

        // JMP 0x0055 from PC 0x0004
        load_word(8'h00, 8'h04);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        expect_out("jmp_pc_start", S_PC, 16'h0004);
        tick();
        compare_all();
        load_word(8'hE0, 8'h55);
        expect_out("jmp_opcode", S_OPC, 16'h0007);
        compare_all();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        expect_out("jmp_lpc", S_PC, 16'h0055);
        tick();
        compare_all();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        expect_out("jmp_lpc_inc", S_PC, 16'h0055);
        tick();
        compare_all();

        // Address mux follows fetch combinationally
        load_word(8'h00, 8'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        load_word(8'h01, 8'h23);
        for (int i = 0; i < 4; i++) begin
            ifc.fetch = ~ifc.fetch;
            #1;
            expect_out(ifc.fetch ? "mux_fetch" : "mux_exec", S_ADDR,
                       ifc.fetch ? 16'h0010 : 16'h0123);
            compare_all();
        end
        ifc.fetch = 1'b1;

        // Halt together with inc_pc, then everything frozen
        load_word(8'h00, 8'h08);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        expect_out("halt_pc",     S_PC,   16'h0009);
        expect_out("halt_flag",   S_HALT, 16'h0001);
        tick();
        compare_all();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
        expect_out("frozen_pc",     S_PC,   16'h0009);
        expect_out("frozen_iraddr", S_IRA,  16'h0008);
        expect_out("frozen_bsel",   S_BSEL, 16'h0000);
        expect_out("frozen_valid",  S_VAL,  16'h0001);
        expect_out("frozen_halted", S_HALT, 16'h0001);
        tick();
        compare_all();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        expect_out("frozen_pc2", S_PC, 16'h0009);
        tick();
        compare_all();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        expect_reset_state("halt_rst");
        tick();
        compare_all();

        // Reset mid-instruction, then a clean SKZ 0x0007
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        expect_out("mid_hi_bsel", S_BSEL, 16'h0001);
        tick();
        compare_all();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        expect_out("mid_rst_bsel",  S_BSEL, 16'h0000);
        expect_out("mid_rst_valid", S_VAL,  16'h0000);
        tick();
        compare_all();
        load_word(8'h20, 8'h07);
        expect_out("mid_opcode", S_OPC, 16'h0001);
        expect_out("mid_iraddr", S_IRA, 16'h0007);
        expect_out("mid_valid",  S_VAL, 16'h0001);
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
